// File: rtl/hp35_word_timer.sv
// Bit-time sequencer for the HP-35 serial ROM bus: it shifts a ROM address out on ia,
// marks the instruction window with sync, and assembles the instruction coming back on is_in.
module hp35_word_timer #(
  parameter int WORD_LEN   = 56,
  parameter int SYNC_START = 45,
  parameter int SYNC_LEN   = 10,
  parameter int ADDR_START = 19
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          addr_in,
  input  logic                addr_valid,
  output logic                addr_ready,
  output logic                ia,
  input  logic                is_in,
  output logic                sync,
  output logic [5:0]          bit_time,
  output logic                word_start,
  output logic [SYNC_LEN-1:0] inst_out,
  output logic                inst_valid
);

  localparam logic [5:0] LAST_BT = 6'(WORD_LEN - 1);
  localparam logic [5:0] SYNC_LO = 6'(SYNC_START);
  localparam logic [5:0] SYNC_HI = 6'(SYNC_START + SYNC_LEN - 1);
  localparam logic [5:0] ADDR_LO = 6'(ADDR_START);
  localparam logic [5:0] ADDR_HI = 6'(ADDR_START + 7);

  logic [7:0]          cur_addr;
  logic [7:0]          pending;
  logic                pending_full;
  // Holds the first SYNC_LEN-1 samples; the last one is taken straight from is_in.
  logic [SYNC_LEN-2:0] shifter;
  logic                in_sync;
  logic                in_addr;
  logic [2:0]          addr_k;
  logic                take;

  assign in_sync    = (bit_time >= SYNC_LO) && (bit_time <= SYNC_HI);
  assign in_addr    = (bit_time >= ADDR_LO) && (bit_time <= ADDR_HI);
  assign addr_k     = 3'(bit_time - ADDR_LO);

  assign sync       = !reset && in_sync;
  assign ia         = !reset && in_addr && cur_addr[addr_k];
  assign word_start = reset || (bit_time == 6'd0);
  assign addr_ready = reset || !pending_full;
  assign take       = addr_valid && !pending_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_time     <= 6'd0;
      cur_addr     <= 8'd0;
      pending      <= 8'd0;
      pending_full <= 1'b0;
      shifter      <= '0;
      inst_out     <= '0;
      inst_valid   <= 1'b0;
    end else begin
      bit_time <= (bit_time == LAST_BT) ? 6'd0 : bit_time + 6'd1;

      // The word boundary is the only point where the outgoing address may change,
      // so ia stays stable across the whole address window.
      if (bit_time == 6'd0 && pending_full) begin
        cur_addr     <= pending;
        pending_full <= 1'b0;
      end
      // A slot that is empty at the boundary edge accepts here; the new address
      // then waits one full word in pending.
      if (take) begin
        pending      <= addr_in;
        pending_full <= 1'b1;
      end

      if (in_sync)
        shifter <= {is_in, shifter[SYNC_LEN-2:1]};

      inst_valid <= (bit_time == SYNC_HI);
      if (bit_time == SYNC_HI)
        inst_out <= {is_in, shifter};
    end
  end

endmodule

// File: tb/tb_hp35_word_timer.sv
// Directed self-checking bench for hp35_word_timer at default parameters.
module tb_hp35_word_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr_in = 8'd0;
  logic       addr_valid = 1'b0;
  logic       addr_ready;
  logic       ia;
  logic       is_in = 1'b0;
  logic       sync;
  logic [5:0] bit_time;
  logic       word_start;
  logic [9:0] inst_out;
  logic       inst_valid;

  int checks = 0;
  int passes = 0;
  int exp_bt = 0;

  hp35_word_timer dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .ia(ia), .is_in(is_in), .sync(sync),
    .bit_time(bit_time), .word_start(word_start), .inst_out(inst_out),
    .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    exp_bt = r ? 0 : ((exp_bt == 55) ? 0 : exp_bt + 1);
  endtask

  task automatic goto(input int bt);
    int n;
    n = 0;
    while (exp_bt != bt && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (bit_time !== 6'(bt)) $display("FAIL goto: bit_time=%0d want %0d", bit_time, bt);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    addr_valid = 1'b1;
    addr_in = 8'hFF;
    tick(); tick(); tick();
    checks++;
    if (bit_time !== 6'd0) $display("FAIL reset_bt: got %0d want 0", bit_time); else passes++;
    checks++;
    if (sync !== 1'b0 || ia !== 1'b0) $display("FAIL reset_sync_ia: sync=%b ia=%b want 0 0", sync, ia); else passes++;
    checks++;
    if (word_start !== 1'b1 || addr_ready !== 1'b1) $display("FAIL reset_ws_rdy: ws=%b rdy=%b want 1 1", word_start, addr_ready); else passes++;
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 10'h000) $display("FAIL reset_inst: v=%b out=%h want 0 000", inst_valid, inst_out); else passes++;
    addr_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (bit_time !== 6'd1 || addr_ready !== 1'b1) $display("FAIL reset_release: bt=%0d rdy=%b want 1 1", bit_time, addr_ready); else passes++;
  endtask

  task automatic test_free_run;
    int nsync, nws;
    nsync = 0;
    nws = 0;
    goto(0);
    for (int c = 0; c < 3 * 56; c++) begin
      checks++;
      if (bit_time !== 6'(exp_bt)) $display("FAIL run_bt: got %0d want %0d", bit_time, exp_bt); else passes++;
      checks++;
      if (sync !== (exp_bt >= 45 && exp_bt <= 54)) $display("FAIL run_sync: bt=%0d sync=%b", exp_bt, sync); else passes++;
      checks++;
      if (word_start !== (exp_bt == 0)) $display("FAIL run_ws: bt=%0d ws=%b", exp_bt, word_start); else passes++;
      checks++;
      if (ia !== 1'b0) $display("FAIL run_ia: bt=%0d ia=%b want 0", exp_bt, ia); else passes++;
      if (sync === 1'b1) nsync++;
      if (word_start === 1'b1) nws++;
      tick();
    end
    checks++;
    if (nsync != 30 || nws != 3) $display("FAIL run_counts: sync=%0d ws=%0d want 30 3", nsync, nws); else passes++;
  endtask

  task automatic check_addr(input logic [7:0] a, input string name);
    goto(18);
    checks++;
    if (ia !== 1'b0) $display("FAIL %s_pre: ia=%b want 0", name, ia); else passes++;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ia !== a[k]) $display("FAIL %s_bit%0d: ia=%b want %b", name, k, ia, a[k]); else passes++;
      tick();
    end
    checks++;
    if (ia !== 1'b0) $display("FAIL %s_post: ia=%b want 0", name, ia); else passes++;
  endtask

  task automatic test_address;
    goto(5);
    addr_in = 8'hA5;
    addr_valid = 1'b1;
    checks++;
    if (addr_ready !== 1'b1) $display("FAIL addr_rdy_before: got %b want 1", addr_ready); else passes++;
    tick();
    addr_valid = 1'b0;
    checks++;
    if (addr_ready !== 1'b0) $display("FAIL addr_rdy_fall: got %b want 0", addr_ready); else passes++;
    check_addr(8'h00, "addr_cur");
    goto(0);
    checks++;
    if (addr_ready !== 1'b0) $display("FAIL addr_rdy_bt0: got %b want 0", addr_ready); else passes++;
    tick();
    checks++;
    if (addr_ready !== 1'b1) $display("FAIL addr_rdy_bt1: got %b want 1", addr_ready); else passes++;
    check_addr(8'hA5, "addr_a5");
  endtask

  task automatic test_instruction;
    logic [9:0] v;
    v = 10'b1100110101;
    goto(45);
    for (int k = 0; k < 10; k++) begin
      is_in = v[k];
      checks++;
      if (inst_valid !== 1'b0 || sync !== 1'b1) $display("FAIL inst_win%0d: v=%b sync=%b want 0 1", k, inst_valid, sync); else passes++;
      tick();
    end
    is_in = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 10'h335) $display("FAIL inst_bt55: v=%b out=%h want 1 335", inst_valid, inst_out); else passes++;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 10'h335) $display("FAIL inst_bt0: v=%b out=%h want 0 335", inst_valid, inst_out); else passes++;
    goto(54);
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 10'h335) $display("FAIL inst_hold: v=%b out=%h want 0 335", inst_valid, inst_out); else passes++;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 10'h000) $display("FAIL inst_zero: v=%b out=%h want 1 000", inst_valid, inst_out); else passes++;
  endtask

  task automatic test_boundary;
    goto(0);
    addr_in = 8'h3C;
    addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    checks++;
    if (addr_ready !== 1'b0) $display("FAIL bnd_rdy: got %b want 0", addr_ready); else passes++;
    check_addr(8'hA5, "bnd_old");
    goto(0);
    tick();
    check_addr(8'h3C, "bnd_new");
  endtask

  task automatic test_back_to_back;
    int n;
    goto(10);
    addr_in = 8'h81;
    addr_valid = 1'b1;
    tick();
    addr_in = 8'h42;
    checks++;
    if (addr_ready !== 1'b0) $display("FAIL b2b_hold: got %b want 0", addr_ready); else passes++;
    n = 0;
    while (addr_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (addr_ready !== 1'b1 || bit_time !== 6'd1) $display("FAIL b2b_release: rdy=%b bt=%0d want 1 1", addr_ready, bit_time); else passes++;
    tick();
    addr_valid = 1'b0;
    checks++;
    if (addr_ready !== 1'b0) $display("FAIL b2b_second: got %b want 0", addr_ready); else passes++;
    check_addr(8'h81, "b2b_first");
    goto(0);
    tick();
    check_addr(8'h42, "b2b_next");
  endtask

  task automatic test_reset_mid_sync;
    goto(45);
    is_in = 1'b1;
    goto(50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bit_time !== 6'd0 || inst_out !== 10'h000 || inst_valid !== 1'b0)
      $display("FAIL rst_mid: bt=%0d out=%h v=%b want 0 000 0", bit_time, inst_out, inst_valid);
    else passes++;
    tick();
    for (int b = 1; b < 55; b++) begin
      checks++;
      if (inst_valid !== 1'b0 || sync !== (b >= 45)) $display("FAIL rst_quiet%0d: v=%b sync=%b", b, inst_valid, sync); else passes++;
      tick();
    end
    is_in = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 10'h3FF) $display("FAIL rst_after: v=%b out=%h want 1 3ff", inst_valid, inst_out); else passes++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_address();
    test_instruction();
    test_boundary();
    test_back_to_back();
    test_reset_mid_sync();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
